ram_mar_unit: RTL and testbench

- Memory stage of the 8-bit CPU, directly downstream of the control block.
- Consumes the control block's active-low memory strobes: \L_MA, \L_MD, \CE and \L_R.
- Holds the 4-bit memory address register (MAR), an 8-bit write-data latch (MDR) and a 16x8 RAM. The RAM drives or samples the shared 8-bit bus.
- A byte-wide valid/ready programming port loads the program into RAM before the CPU runs.

---
 rtl/ram_mar_unit.sv | 131 +++++++++++++
 tb/tb_ram_mar_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_mar_unit.sv
// ram_mar_unit: MAR, MDR and RAM memory stage with a valid/ready program loader.
// Define MEM_CONFLICT_CHECK_EN to build the sticky strobe-conflict flag on err.
module ram_mar_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  input  logic              n_load_mar_addr,
  input  logic              n_load_mar_data,
  input  logic              n_ram_en,
  input  logic              n_ram_load,
  input  logic              prog_mode,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [ADDR_W:0]   prog_count,
  output logic              err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_CPU,
    S_PROG_IDLE,
    S_PROG_WRITE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_cpu;
  logic              in_write;
  logic              accept;

  assign in_cpu     = (state == S_CPU);
  assign in_write   = (state == S_PROG_WRITE);
  assign prog_ready = (state == S_PROG_IDLE) & prog_mode;
  assign accept     = prog_valid & prog_ready;
  assign bus_drive  = in_cpu & ~n_ram_en;
  assign bus_out    = bus_drive ? mem[mar] : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CPU: begin
        if (prog_mode) state_nxt = S_PROG_IDLE;
      end
      S_PROG_IDLE: begin
        if (!prog_mode)  state_nxt = S_CPU;
        else if (accept) state_nxt = S_PROG_WRITE;
      end
      S_PROG_WRITE: begin
        state_nxt = prog_mode ? S_PROG_IDLE : S_CPU;
      end
      default: state_nxt = S_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_CPU;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mar <= '0;
      mdr <= '0;
    end else if (in_cpu) begin
      if (!n_load_mar_addr) mar <= bus_in[ADDR_W-1:0];
      if (!n_load_mar_data) mdr <= bus_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_addr <= '0;
      wb_data <= '0;
    end else if (accept) begin
      wb_addr <= prog_addr;
      wb_data <= prog_data;
    end
  end

  // CPU store uses pre-edge mar/mdr, so same-edge loads never affect it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (in_write) begin
      mem[wb_addr] <= wb_data;
    end else if (in_cpu && !n_ram_load) begin
      mem[mar] <= mdr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prog_count <= '0;
    end else if (in_cpu && prog_mode) begin
      prog_count <= '0;
    end else if (in_write && prog_count != CNT_MAX) begin
      prog_count <= prog_count + 1'b1;
    end
  end

`ifdef MEM_CONFLICT_CHECK_EN
  logic conflict;

  assign conflict = in_cpu & (
    (~n_ram_en        & ~n_ram_load)      |
    (~n_ram_en        & ~n_load_mar_data) |
    (~n_load_mar_addr & ~n_load_mar_data));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       err <= 1'b0;
    else if (conflict) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_mar_unit.sv
// tb_ram_mar_unit: randomized scoreboard bench for ram_mar_unit.
// Reads are queued by the driver and checked by an independent bus monitor.
module tb_ram_mar_unit;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

`ifdef MEM_CONFLICT_CHECK_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_drive;
  logic          n_load_mar_addr;
  logic          n_load_mar_data;
  logic          n_ram_en;
  logic          n_ram_load;
  logic          prog_mode;
  logic          prog_valid;
  logic          prog_ready;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [AW:0]   prog_count;
  logic          err;

  always #5 clk = ~clk;

  ram_mar_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .bus_in          (bus_in),
    .bus_out         (bus_out),
    .bus_drive       (bus_drive),
    .n_load_mar_addr (n_load_mar_addr),
    .n_load_mar_data (n_load_mar_data),
    .n_ram_en        (n_ram_en),
    .n_ram_load      (n_ram_load),
    .prog_mode       (prog_mode),
    .prog_valid      (prog_valid),
    .prog_ready      (prog_ready),
    .prog_addr       (prog_addr),
    .prog_data       (prog_data),
    .prog_count      (prog_count),
    .err             (err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [AW-1:0] mar_m;
  logic [DW-1:0] mdr_m;
  int            cnt_m;
  bit            err_m;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    mar_m = '0;
    mdr_m = '0;
    cnt_m = 0;
    err_m = 1'b0;
  endtask

  task automatic idle_strobes();
    n_load_mar_addr = 1'b1;
    n_load_mar_data = 1'b1;
    n_ram_en        = 1'b1;
    n_ram_load      = 1'b1;
  endtask

  task automatic rand_strobes();
    n_load_mar_addr = 1'($urandom);
    n_load_mar_data = 1'($urandom);
    n_ram_en        = 1'($urandom);
    n_ram_load      = 1'($urandom);
    bus_in          = DW'($urandom);
  endtask

  // One CPU-state cycle; flags are active-high requests for each strobe
  task automatic cpu_cycle(input bit ma, input bit md, input bit ce,
                           input bit lr, input logic [DW-1:0] b);
    n_load_mar_addr = !ma;
    n_load_mar_data = !md;
    n_ram_en        = !ce;
    n_ram_load      = !lr;
    bus_in          = b;
    if (ce) exp_q.push_back(mem_m[mar_m]);
    if (CC && ((ce && lr) || (ce && md) || (ma && md))) err_m = 1'b1;
    if (lr) mem_m[mar_m] = mdr_m;
    if (ma) mar_m = b[AW-1:0];
    if (md) mdr_m = b;
    @(negedge clk);
    chk("err", err, err_m);
    chk("cpu_prog_ready", prog_ready, 0);
  endtask

  task automatic read_addr(input logic [AW-1:0] a);
    logic [DW-1:0] b;
    b = {4'($urandom), a};
    cpu_cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
    cpu_cycle(1'b0, 1'b0, 1'b1, 1'b0, DW'($urandom));
  endtask

  task automatic enter_prog();
    idle_strobes();
    prog_mode = 1'b1;
    @(negedge clk);
    cnt_m = 0;
    chk("enter_prog_count", prog_count, 0);
  endtask

  task automatic exit_prog();
    idle_strobes();
    prog_mode  = 1'b0;
    prog_valid = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: plain write, 1: drop prog_mode during the write, 2: reset mid-write
  task automatic prog_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int mode);
    int n;
    n = 0;
    prog_addr  = a;
    prog_data  = d;
    prog_valid = 1'b1;
    rand_strobes();
    #4;
    while (prog_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("prog_ready_accept", prog_ready, 1);
    @(negedge clk);
    prog_valid = 1'b0;
    prog_addr  = ~a;
    prog_data  = ~d;
    if (mode == 1) begin
      prog_mode = 1'b0;
      n_ram_en  = 1'b0;
    end
    if (mode == 2) begin
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_prog_ready", prog_ready, 0);
      chk("arst_prog_count", prog_count, 0);
      chk("arst_bus_drive", bus_drive, 0);
      model_reset();
      prog_mode = 1'b0;
      idle_strobes();
      @(negedge clk);
      resetn = 1'b1;
    end else begin
      #4;
      chk("wr_prog_ready", prog_ready, 0);
      chk("wr_bus_drive", bus_drive, 0);
      @(negedge clk);
      mem_m[a] = d;
      if (cnt_m < DEPTH) cnt_m++;
      chk("prog_count", prog_count, cnt_m);
      if (mode == 1) idle_strobes();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (bus_drive === 1'b1) begin
        if (exp_q.size() == 0) chk("bus_drive_unexpected", bus_drive, 0);
        else chk("bus_out", bus_out, exp_q.pop_front());
      end else begin
        chk("bus_out_idle", bus_out, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_strobes();
    bus_in     = '0;
    prog_mode  = 1'b0;
    prog_valid = 1'b0;
    prog_addr  = '0;
    prog_data  = '0;
    model_reset();
    #2;
    chk("rst_prog_ready", prog_ready, 0);
    chk("rst_prog_count", prog_count, 0);
    chk("rst_bus_drive", bus_drive, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    enter_prog();
    prog_write(4'd3, 8'hA5, 0);
    exit_prog();

    cpu_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hF3);
    cpu_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cpu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cpu_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
    cpu_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h5C);
    cpu_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    cpu_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cpu_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h02);
    cpu_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    read_addr(4'd7);
    cpu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    cpu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cpu_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    enter_prog();
    prog_write(4'd15, 8'h11, 1);
    read_addr(4'd15);

    for (int i = 0; i < 300; i++) begin
      prog_valid = 1'($urandom);
      prog_addr  = AW'($urandom);
      prog_data  = DW'($urandom);
      cpu_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                DW'($urandom));
    end
    prog_valid = 1'b0;
    cpu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    enter_prog();
    for (int i = 0; i < 18; i++) prog_write(AW'($urandom), DW'($urandom), 0);
    exit_prog();
    for (int a = 0; a < DEPTH; a++) read_addr(AW'(a));

    enter_prog();
    prog_write(4'd9, 8'h3C, 0);
    prog_write(4'd5, 8'hEE, 2);
    chk("post_rst_err", err, 0);
    for (int a = 0; a < DEPTH; a++) read_addr(AW'(a));

    for (int i = 0; i < 100; i++) begin
      cpu_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                DW'($urandom));
    end
    cpu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
